// File: rtl/pgm_pkg.sv
// Shared encodings for the dealer-facing player: command (MORE) codes,
// result (WIN) codes, default bust limit and the player FSM state set.
package pgm_pkg;

    typedef enum logic [1:0] {
        CMD_STOP  = 2'b00,
        CMD_HIT_A = 2'b01,
        CMD_HIT_B = 2'b10,
        CMD_DEAL  = 2'b11
    } more_e;

    localparam logic [1:0] WIN_A    = 2'b00;
    localparam logic [1:0] WIN_B    = 2'b01;
    localparam logic [1:0] WIN_NONE = 2'b10;

    localparam int MAXH_DEF = 10;

    typedef enum logic [3:0] {
        S_IDLE,
        S_DEAL_CMD,
        S_DEAL_WAIT,
        S_DEAL_B,
        S_DECIDE,
        S_HIT_CMD,
        S_HIT_WAIT,
        S_HIT_CHK,
        S_STOP_CMD,
        S_RES_WAIT,
        S_BUST_RES,
        S_DONE,
        S_ERR
    } state_e;

endpackage

// File: rtl/pgm_player_policy.sv
// Combinational threshold policy and shadow result for pgm_player.
// Ports: hand_a/hand_b (shadow sums) -> more (next command), sh_win/sh_sum.
module pgm_player_policy
    import pgm_pkg::*;
#(
    parameter int MAXH         = MAXH_DEF,
    parameter int PLAYER_STAND = 7,
    parameter int DEALER_STAND = 6
) (
    input  logic [4:0] hand_a,
    input  logic [4:0] hand_b,
    output more_e      more,
    output logic [1:0] sh_win,
    output logic [3:0] sh_sum
);

    localparam logic [4:0] MX = 5'(MAXH);
    localparam logic [4:0] PS = 5'(PLAYER_STAND);
    localparam logic [4:0] DS = 5'(DEALER_STAND);

    logic a_ok;
    logic b_ok;

    assign a_ok = (hand_a <= MX);
    assign b_ok = (hand_b <= MX);

    always_comb begin
        more = CMD_STOP;
        if (hand_a < PS) begin
            more = CMD_HIT_A;
        end else if (hand_b < DS) begin
            more = CMD_HIT_B;
        end
    end

    // A non-bust winning hand never exceeds MAXH, so 4 bits carry it.
    always_comb begin
        sh_win = WIN_NONE;
        sh_sum = 4'd0;
        if (a_ok && ((hand_a > hand_b) || !b_ok)) begin
            sh_win = WIN_A;
            sh_sum = hand_a[3:0];
        end else if (b_ok && ((hand_b > hand_a) || !a_ok)) begin
            sh_win = WIN_B;
            sh_sum = hand_b[3:0];
        end
    end

endmodule

// File: rtl/pgm_player.sv
// Autonomous card-game player: drives dealer commands, tracks shadow hands,
// latches and cross-checks the result.
// Ports: CLK, RESET (sync, active-high), START; dealer response OUT_VALID,
// CARD, WIN, SUM; commands IN_VALID, BUTTON, MORE; status HAND_A, HAND_B,
// DONE, RES_WIN, RES_SUM, MISMATCH, TO_ERR.
// Optional macro PGM_PLAYER_STATS_EN adds CARD_CNT and GAME_CYC outputs.
module pgm_player
    import pgm_pkg::*;
#(
    parameter int MAXH         = MAXH_DEF,
    parameter int PLAYER_STAND = 7,
    parameter int DEALER_STAND = 6,
    parameter int TIMEOUT      = 15
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       START,
    input  logic       OUT_VALID,
    input  logic [3:0] CARD,
    input  logic [1:0] WIN,
    input  logic [3:0] SUM,
    output logic       IN_VALID,
    output logic       BUTTON,
    output logic [1:0] MORE,
    output logic [4:0] HAND_A,
    output logic [4:0] HAND_B,
    output logic       DONE,
    output logic [1:0] RES_WIN,
    output logic [3:0] RES_SUM,
    output logic       MISMATCH,
`ifdef PGM_PLAYER_STATS_EN
    output logic [3:0] CARD_CNT,
    output logic [7:0] GAME_CYC,
`endif
    output logic       TO_ERR
);

    localparam logic [4:0] MX = 5'(MAXH);
    localparam logic [7:0] TO = 8'(TIMEOUT);

    state_e     state;
    state_e     state_n;
    more_e      more_q;
    more_e      pol_more;
    logic [4:0] hand_a;
    logic [4:0] hand_b;
    logic [7:0] to_cnt;
    logic [1:0] res_win;
    logic [3:0] res_sum;
    logic       mism;
    logic [1:0] sh_win;
    logic [3:0] sh_sum;
    logic       strobe;
    logic       to_hit;
    logic       bust;

    pgm_player_policy #(
        .MAXH        (MAXH),
        .PLAYER_STAND(PLAYER_STAND),
        .DEALER_STAND(DEALER_STAND)
    ) u_policy (
        .hand_a(hand_a),
        .hand_b(hand_b),
        .more  (pol_more),
        .sh_win(sh_win),
        .sh_sum(sh_sum)
    );

    assign strobe = (state == S_DEAL_CMD) ||
                    (state == S_HIT_CMD)  ||
                    (state == S_STOP_CMD);
    assign to_hit = (to_cnt == TO);
    // Only the hit hand can move past MAXH; deal cards are at most 8.
    assign bust   = (hand_a > MX) || (hand_b > MX);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:      if (START) state_n = S_DEAL_CMD;
            S_DEAL_CMD:  state_n = S_DEAL_WAIT;
            S_DEAL_WAIT: begin
                if (OUT_VALID)   state_n = S_DEAL_B;
                else if (to_hit) state_n = S_ERR;
            end
            S_DEAL_B:    state_n = S_DECIDE;
            S_DECIDE: begin
                if (pol_more == CMD_STOP) state_n = S_STOP_CMD;
                else                      state_n = S_HIT_CMD;
            end
            S_HIT_CMD:   state_n = S_HIT_WAIT;
            S_HIT_WAIT: begin
                if (OUT_VALID)   state_n = S_HIT_CHK;
                else if (to_hit) state_n = S_ERR;
            end
            S_HIT_CHK: begin
                if (bust) state_n = S_BUST_RES;
                else      state_n = S_DECIDE;
            end
            S_STOP_CMD:  state_n = S_RES_WAIT;
            S_RES_WAIT: begin
                if (OUT_VALID)   state_n = S_DONE;
                else if (to_hit) state_n = S_ERR;
            end
            S_BUST_RES:  state_n = S_DONE;
            default:     state_n = state;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            more_q  <= CMD_STOP;
            hand_a  <= 5'd0;
            hand_b  <= 5'd0;
            to_cnt  <= 8'd0;
            res_win <= 2'b00;
            res_sum <= 4'd0;
            mism    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (START) more_q <= CMD_DEAL;
                end
                S_DEAL_CMD, S_HIT_CMD, S_STOP_CMD: begin
                    to_cnt <= 8'd0;
                end
                S_DEAL_WAIT: begin
                    if (OUT_VALID) hand_a <= hand_a + {1'b0, CARD};
                    else           to_cnt <= to_cnt + 8'd1;
                end
                S_DEAL_B: begin
                    hand_b <= hand_b + {1'b0, CARD};
                end
                S_DECIDE: begin
                    more_q <= pol_more;
                end
                S_HIT_WAIT: begin
                    if (OUT_VALID) begin
                        if (more_q == CMD_HIT_A)
                            hand_a <= hand_a + {1'b0, CARD};
                        else
                            hand_b <= hand_b + {1'b0, CARD};
                    end else begin
                        to_cnt <= to_cnt + 8'd1;
                    end
                end
                S_RES_WAIT: begin
                    if (OUT_VALID) begin
                        to_cnt  <= to_cnt;
                        res_win <= WIN;
                        res_sum <= SUM;
                        mism    <= (WIN != sh_win) || (SUM != sh_sum);
                    end else begin
                        to_cnt <= to_cnt + 8'd1;
                    end
                end
                // Dealer keeps OUT_VALID high with the result after a bust.
                S_BUST_RES: begin
                    res_win <= WIN;
                    res_sum <= SUM;
                    mism    <= (WIN != sh_win) || (SUM != sh_sum);
                end
                default: begin
                    to_cnt <= to_cnt;
                end
            endcase
        end
    end

`ifdef PGM_PLAYER_STATS_EN
    logic [3:0] card_cnt;
    logic [7:0] game_cyc;
    logic       card_in;
    logic       in_game;

    assign card_in = ((state == S_DEAL_WAIT) && OUT_VALID) ||
                     (state == S_DEAL_B) ||
                     ((state == S_HIT_WAIT) && OUT_VALID);
    assign in_game = (state != S_IDLE) &&
                     (state != S_DONE) &&
                     (state != S_ERR);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            card_cnt <= 4'd0;
            game_cyc <= 8'd0;
        end else begin
            if (card_in && (card_cnt != 4'hF))
                card_cnt <= card_cnt + 4'd1;
            if (in_game && (game_cyc != 8'hFF))
                game_cyc <= game_cyc + 8'd1;
        end
    end

    assign CARD_CNT = card_cnt;
    assign GAME_CYC = game_cyc;
`endif

    assign IN_VALID = strobe;
    assign BUTTON   = strobe;
    assign MORE     = more_q;
    assign HAND_A   = hand_a;
    assign HAND_B   = hand_b;
    assign DONE     = (state == S_DONE);
    assign RES_WIN  = res_win;
    assign RES_SUM  = res_sum;
    assign MISMATCH = mism;
    assign TO_ERR   = (state == S_ERR);

endmodule

// File: tb/tb_pgm_player.sv
// Directed bench for pgm_player with a scripted dealer model.
// Dealer answers 2 cycles after each strobe; all I/O on the falling edge.
module tb_pgm_player;

    logic       clk;
    logic       RESET;
    logic       START;
    logic       OUT_VALID;
    logic [3:0] CARD;
    logic [1:0] WIN;
    logic [3:0] SUM;
    logic       IN_VALID;
    logic       BUTTON;
    logic [1:0] MORE;
    logic [4:0] HAND_A;
    logic [4:0] HAND_B;
    logic       DONE;
    logic [1:0] RES_WIN;
    logic [3:0] RES_SUM;
    logic       MISMATCH;
    logic       TO_ERR;
`ifdef PGM_PLAYER_STATS_EN
    logic [3:0] card_cnt;
    logic [7:0] game_cyc;
`endif

    int n_chk  = 0;
    int n_pass = 0;
    bit prev_iv = 0;

    wire [22:0] outs = {IN_VALID, BUTTON, MORE, HAND_A, HAND_B, DONE,
                        RES_WIN, RES_SUM, MISMATCH, TO_ERR};

    pgm_player dut (
        .CLK      (clk),
        .RESET    (RESET),
        .START    (START),
        .OUT_VALID(OUT_VALID),
        .CARD     (CARD),
        .WIN      (WIN),
        .SUM      (SUM),
        .IN_VALID (IN_VALID),
        .BUTTON   (BUTTON),
        .MORE     (MORE),
        .HAND_A   (HAND_A),
        .HAND_B   (HAND_B),
        .DONE     (DONE),
        .RES_WIN  (RES_WIN),
        .RES_SUM  (RES_SUM),
        .MISMATCH (MISMATCH),
`ifdef PGM_PLAYER_STATS_EN
        .CARD_CNT (card_cnt),
        .GAME_CYC (game_cyc),
`endif
        .TO_ERR   (TO_ERR)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    // Every strobe is a single cycle with BUTTON mirroring IN_VALID.
    always @(negedge clk) begin
        if (IN_VALID || BUTTON) check("btn_eq", BUTTON, IN_VALID);
        if (prev_iv) check("pulse1", IN_VALID, 1'b0);
        prev_iv = IN_VALID;
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        START = 1'b0;
        OUT_VALID = 1'b0;
        CARD = 4'd0;
        WIN = 2'b00;
        SUM = 4'd0;
        tick();
        tick();
        RESET = 1'b0;
    endtask

    // Returns two cycles after the strobe, when the dealer answers.
    task automatic await_cmd(input logic [1:0] exp, input string tag);
        int n = 0;
        while (!IN_VALID && n < 40) begin
            tick();
            n++;
        end
        check({tag, "_strobe"}, IN_VALID, 1'b1);
        check({tag, "_more"}, MORE, exp);
        tick();
        tick();
    endtask

    task automatic deal(input logic [3:0] a, input logic [3:0] b,
                        input string tag);
        await_cmd(2'b11, tag);
        OUT_VALID = 1'b1;
        CARD = a;
        tick();
        CARD = b;
        tick();
        OUT_VALID = 1'b0;
        CARD = 4'd0;
    endtask

    task automatic hit(input logic [1:0] m, input logic [3:0] c,
                       input string tag);
        await_cmd(m, tag);
        OUT_VALID = 1'b1;
        CARD = c;
        tick();
        OUT_VALID = 1'b0;
        CARD = 4'd0;
    endtask

    task automatic stop(input logic [1:0] w, input logic [3:0] s,
                        input string tag);
        await_cmd(2'b00, tag);
        OUT_VALID = 1'b1;
        WIN = w;
        SUM = s;
        tick();
        OUT_VALID = 1'b0;
    endtask

    task automatic bust(input logic [1:0] m, input logic [3:0] c,
                        input logic [1:0] w, input logic [3:0] s,
                        input string tag);
        await_cmd(m, tag);
        OUT_VALID = 1'b1;
        CARD = c;
        WIN = w;
        SUM = s;
        tick();
        tick();
        tick();
        OUT_VALID = 1'b0;
        CARD = 4'd0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        bit saw = 0;
        while (!DONE && n < 30) begin
            tick();
            n++;
            if (IN_VALID) saw = 1;
        end
        check({tag, "_done"}, DONE, 1'b1);
        check({tag, "_nostrobe"}, saw, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        bit saw;
        int n;

        do_reset();
        check("rst_outs", outs, 23'd0);

        saw = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (IN_VALID) saw = 1;
        end
        check("idle_nostart", saw, 1'b0);

        // Scenario 1: two hits then stop, A wins with 8.
        START = 1'b1;
        deal(4'd5, 4'd4, "s1d");
        check("s1_ha0", HAND_A, 5'd5);
        check("s1_hb0", HAND_B, 5'd4);
        hit(2'b01, 4'd3, "s1h1");
        check("s1_ha1", HAND_A, 5'd8);
        hit(2'b10, 4'd2, "s1h2");
        check("s1_hb1", HAND_B, 5'd6);
        stop(2'b00, 4'd8, "s1s");
        wait_done("s1");
        check("s1_win", RES_WIN, 2'b00);
        check("s1_sum", RES_SUM, 4'd8);
        check("s1_mism", MISMATCH, 1'b0);
`ifdef PGM_PLAYER_STATS_EN
        check("s1_cards", card_cnt, 4'd4);
`endif

        // Scenario 2: A busts on 13, dealer reports B with 6.
        do_reset();
        check("s2_rst", outs, 23'd0);
        START = 1'b1;
        deal(4'd6, 4'd6, "s2d");
        bust(2'b01, 4'd7, 2'b01, 4'd6, "s2h");
        wait_done("s2");
        check("s2_ha", HAND_A, 5'd13);
        check("s2_win", RES_WIN, 2'b01);
        check("s2_sum", RES_SUM, 4'd6);
        check("s2_mism", MISMATCH, 1'b0);

        // Scenario 3: both 7, immediate stop, tie.
        do_reset();
        START = 1'b1;
        deal(4'd7, 4'd7, "s3d");
        stop(2'b10, 4'd0, "s3s");
        wait_done("s3");
        check("s3_win", RES_WIN, 2'b10);
        check("s3_sum", RES_SUM, 4'd0);
        check("s3_mism", MISMATCH, 1'b0);

        // Scenario 4: dealer silent after the deal.
        do_reset();
        START = 1'b1;
        await_cmd(2'b11, "s4d");
        saw = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (IN_VALID) saw = 1;
        end
        check("s4_early", TO_ERR, 1'b0);
        n = 0;
        while (!TO_ERR && n < 20) begin
            tick();
            n++;
            if (IN_VALID) saw = 1;
        end
        check("s4_toerr", TO_ERR, 1'b1);
        check("s4_nostrobe", saw, 1'b0);
        check("s4_done", DONE, 1'b0);
        tick();
        check("s4_sticky", TO_ERR, 1'b1);

        // Scenario 5: dealer misreports SUM, then reset mid-hit.
        do_reset();
        START = 1'b1;
        deal(4'd5, 4'd4, "s5d");
        hit(2'b01, 4'd3, "s5h1");
        hit(2'b10, 4'd2, "s5h2");
        stop(2'b00, 4'd9, "s5s");
        wait_done("s5");
        check("s5_mism", MISMATCH, 1'b1);
        check("s5_sum", RES_SUM, 4'd9);

        do_reset();
        START = 1'b1;
        deal(4'd5, 4'd4, "s5r");
        await_cmd(2'b01, "s5rh");
        OUT_VALID = 1'b1;
        CARD = 4'd3;
        RESET = 1'b1;
        START = 1'b0;
        tick();
        check("s5_rst_outs", outs, 23'd0);
        RESET = 1'b0;
        OUT_VALID = 1'b0;
        CARD = 4'd0;
        tick();
        check("s5_rst_idle", outs, 23'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
